memory_unit: RTL and testbench

Memory-side responder for the CPU control sequencer. It owns the MAR and MDR registers and a synchronous word RAM, and services the `mem_read`/`mem_write` strobes the sequencer issues during fetch, load and store. Each access completes after a fixed, parameterised latency and is acknowledged with `mem_done`. The MDR is driven onto the datapath bus on request.

---
 rtl/memory_unit_pkg.sv | 16 +
 rtl/word_ram.sv | 30 +++
 rtl/memory_unit.sv | 145 ++++++++++++++
 tb/tb_memory_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_pkg.sv
// Shared CPU memory-side definitions.
// Holds the memory FSM state encoding, the default word-address width,
// the datapath word width and the width of the access latency counter.
package memory_unit_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int DATA_W     = 32;
  localparam int LAT_W      = 4;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word RAM.
// Ports:
//   clock - rising-edge clock
//   we    - write enable, commits din to addr on the edge
//   addr  - word address
//   din   - write data
//   dout  - registered read data of addr (old contents on a same-edge write)
module word_ram
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int WORD_W = DATA_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/memory_unit.sv
// Memory-side responder for the CPU control sequencer.
// Owns MAR, MDR and a word RAM; services edge-detected read/write strobes
// with fixed latencies and acknowledges each access with a mem_done pulse.
// Ports:
//   clock, reset         - clock and synchronous active-high reset
//   bus_in               - datapath bus value
//   mari / mdri          - load MAR / MDR from bus_in (IDLE only)
//   mdro                 - drive MDR onto mdr_out
//   mem_read / mem_write - request levels (rising edge starts an access)
//   mdr_out              - MDR when mdro=1, else 0
//   mem_busy             - access in flight
//   mem_done             - one-cycle completion pulse
//   proto_err            - one-cycle pulse on an illegal request
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mari,
  input  logic              mdri,
  input  logic              mdro,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] mdr_out,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              proto_err
);

  localparam logic [LAT_W-1:0] RD_LAST = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LAST = LAT_W'(WRITE_LAT - 1);

  mem_state_t        state, state_nxt;
  logic [LAT_W-1:0]  count, count_nxt;
  logic              mem_read_p1, mem_write_p1;
  logic              rd_edge, wr_edge;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_we;
  logic              mdr_from_ram;
  logic              done_nxt, err_nxt;

  assign rd_edge  = mem_read  & ~mem_read_p1;
  assign wr_edge  = mem_write & ~mem_write_p1;
  assign mem_busy = (state != MEM_IDLE);
  assign mdr_out  = mdro ? mdr : '0;

  // The RAM reads MAR every cycle; the registered dout is consumed on the
  // final edge of a read, so the one-cycle RAM latency sits inside READ_LAT.
  // A reset on the commit edge suppresses the write.
  word_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we & ~reset),
    .addr  (mar),
    .din   (mdr),
    .dout  (ram_dout)
  );

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    ram_we       = 1'b0;
    mdr_from_ram = 1'b0;
    unique case (state)
      MEM_IDLE: begin
        count_nxt = '0;
        if (rd_edge) begin
          state_nxt = MEM_RD_WAIT;
          err_nxt   = wr_edge;
        end else if (wr_edge) begin
          state_nxt = MEM_WR_WAIT;
        end
      end
      MEM_RD_WAIT: begin
        err_nxt = mari | mdri | rd_edge | wr_edge;
        if (count == RD_LAST) begin
          state_nxt    = MEM_IDLE;
          count_nxt    = '0;
          done_nxt     = 1'b1;
          mdr_from_ram = 1'b1;
        end else begin
          count_nxt = count + LAT_W'(1);
        end
      end
      MEM_WR_WAIT: begin
        err_nxt = mari | mdri | rd_edge | wr_edge;
        if (count == WR_LAST) begin
          state_nxt = MEM_IDLE;
          count_nxt = '0;
          done_nxt  = 1'b1;
          ram_we    = 1'b1;
        end else begin
          count_nxt = count + LAT_W'(1);
        end
      end
      default: begin
        state_nxt = MEM_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= MEM_IDLE;
      count        <= '0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      mem_done     <= 1'b0;
      proto_err    <= 1'b0;
      mar          <= '0;
      mdr          <= '0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      mem_read_p1  <= mem_read;
      mem_write_p1 <= mem_write;
      mem_done     <= done_nxt;
      proto_err    <= err_nxt;
      if (state == MEM_IDLE) begin
        if (mari) begin
          mar <= bus_in[ADDR_W-1:0];
        end
        // With mem_read raised the MDR is reserved for the RAM data.
        if (mdri && !mem_read) begin
          mdr <= bus_in;
        end
      end else if (mdr_from_ram) begin
        mdr <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
module tb_memory_unit;

  localparam int ADDR_W    = 9;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 2;

  logic        clock;
  logic        reset;
  logic [31:0] bus_in;
  logic        mari, mdri, mdro, mem_read, mem_write;
  logic [31:0] mdr_out;
  logic        mem_busy, mem_done, proto_err;

  int tests    = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  memory_unit #(
    .ADDR_W    (ADDR_W),
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus_in    (bus_in),
    .mari      (mari),
    .mdri      (mdri),
    .mdro      (mdro),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mdr_out   (mdr_out),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .proto_err (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: an access is a transaction with a number of edges
  // remaining; completion applies its effect and raises done.
  logic [31:0]       m_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] m_mar;
  logic [31:0]       m_mdr;
  int                m_rem;
  bit                m_is_rd, m_pr, m_pw, m_done, m_err;
  bit                model_ok = 1'b0;

  always @(posedge clock) begin
    bit re, we;
    if (reset) begin
      m_mar = '0; m_mdr = '0; m_rem = 0; m_pr = 0; m_pw = 0;
      m_done = 0; m_err = 0; model_ok = 1'b1;
    end else begin
      re = mem_read && !m_pr;
      we = mem_write && !m_pw;
      m_done = 0;
      m_err  = 0;
      if (m_rem == 0) begin
        if (mari) m_mar = bus_in[ADDR_W-1:0];
        if (mdri && !mem_read) m_mdr = bus_in;
        if (re) begin
          m_is_rd = 1; m_rem = READ_LAT; m_err = we;
        end else if (we) begin
          m_is_rd = 0; m_rem = WRITE_LAT;
        end
      end else begin
        m_err = mari || mdri || re || we;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_is_rd) m_mdr = m_mem[m_mar];
          else         m_mem[m_mar] = m_mdr;
          m_done = 1;
        end
      end
      m_pr = mem_read;
      m_pw = mem_write;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (mem_done === 1'b1) done_cnt++;
    if (proto_err === 1'b1) err_cnt++;
    if (model_ok) begin
      tests++;
      if (mem_busy !== (m_rem != 0)) begin
        failures++;
        $display("FAIL busy @%0t: got %b, want %b", $time, mem_busy, (m_rem != 0));
      end
      tests++;
      if (mem_done !== m_done) begin
        failures++;
        $display("FAIL done @%0t: got %b, want %b", $time, mem_done, m_done);
      end
      tests++;
      if (proto_err !== m_err) begin
        failures++;
        $display("FAIL proto_err @%0t: got %b, want %b", $time, proto_err, m_err);
      end
      tests++;
      if (mdr_out !== (mdro ? m_mdr : 32'h0)) begin
        failures++;
        $display("FAIL mdr_out @%0t: got %h, want %h", $time, mdr_out, (mdro ? m_mdr : 32'h0));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic r, input logic w, input logic ma,
                      input logic md, input logic mo, input logic [31:0] b);
    reset = rst; mem_read = r; mem_write = w; mari = ma; mdri = md; mdro = mo; bus_in = b;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    step(0, 0, 0, 1, 0, 0, a);
    step(0, 0, 0, 0, 1, 0, d);
    step(0, 0, 1, 0, 0, 0, 32'h0);
    idle(WRITE_LAT);
  endtask

  task automatic load(input logic [31:0] a);
    step(0, 0, 0, 1, 0, 0, a);
    step(0, 1, 0, 0, 0, 0, 32'h0);
    idle(READ_LAT);
  endtask

  task automatic peek(input string name, input logic [31:0] exp);
    mdro = 1'b1;
    #1;
    check(name, mdr_out, exp);
    mdro = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    logic r, w;
    logic [31:0] b;

    reset = 1; bus_in = 0; mari = 0; mdri = 0; mdro = 0; mem_read = 0; mem_write = 0;
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    check("reset_busy", {31'h0, mem_busy}, 32'h0);
    check("reset_done", {31'h0, mem_done}, 32'h0);
    check("reset_err", {31'h0, proto_err}, 32'h0);
    peek("reset_mdr", 32'h0);
    idle(1);

    for (int i = 0; i < 16; i++) store(i, 32'hA500_0000 | i);

    // Fetch: read with mdri held alongside mem_read.
    store(32'd5, 32'h2A00_0013);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 32'd5);
    d0 = done_cnt;
    repeat (3) step(0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 0, 0, 32'h0);
    idle(1);
    peek("fetch_mdr", 32'h2A00_0013);
    check("fetch_done_once", done_cnt - d0, 32'd1);
    check("fetch_no_retrigger", {31'h0, mem_busy}, 32'h0);

    // Store then load at the top address.
    store(32'h1FF, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    peek("mdr_cleared", 32'h0);
    load(32'h1FF);
    peek("load_1ff", 32'hDEAD_BEEF);

    // Simultaneous read and write edges.
    store(32'h20, 32'hCAFE_0001);
    step(0, 0, 0, 1, 0, 0, 32'h20);
    step(0, 0, 0, 0, 1, 0, 32'h1234_5678);
    e0 = err_cnt;
    step(0, 1, 1, 0, 0, 0, 32'h0);
    idle(READ_LAT + 1);
    check("simul_err_once", err_cnt - e0, 32'd1);
    peek("simul_read", 32'hCAFE_0001);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    load(32'h20);
    peek("simul_ram_kept", 32'hCAFE_0001);

    // Busy violations: mari/mdri during a read.
    step(0, 0, 0, 1, 0, 0, 32'h20);
    e0 = err_cnt;
    step(0, 1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 1, 0, 32'd7);
    idle(READ_LAT);
    check("busy_err_once", err_cnt - e0, 32'd1);
    peek("busy_read_addr", 32'hCAFE_0001);
    step(0, 1, 0, 0, 0, 0, 32'h0);
    idle(READ_LAT);
    peek("busy_mar_frozen", 32'hCAFE_0001);

    // Reset on the commit edge of a write.
    store(32'h10, 32'h1111_1111);
    step(0, 0, 0, 1, 0, 0, 32'h10);
    step(0, 0, 0, 0, 1, 0, 32'h5555_5555);
    d0 = done_cnt;
    step(0, 0, 1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    check("rst_busy", {31'h0, mem_busy}, 32'h0);
    check("rst_done", {31'h0, mem_done}, 32'h0);
    check("rst_err", {31'h0, proto_err}, 32'h0);
    peek("rst_mdr", 32'h0);
    idle(2);
    check("rst_no_done", done_cnt - d0, 32'd0);
    load(32'h10);
    peek("rst_ram_kept", 32'h1111_1111);

    // Address truncation.
    store(32'h0000_0203, 32'h0BAD_F00D);
    load(32'h3);
    peek("trunc_word3", 32'h0BAD_F00D);
    load(32'hFFFF_FE03);
    peek("trunc_high", 32'h0BAD_F00D);

    // Randomized traffic over the preloaded words 0..15.
    step(0, 0, 0, 1, 0, 0, 32'h0);
    r = 0; w = 0;
    for (int i = 0; i < 600; i++) begin
      logic ma, md;
      if ($urandom % 3 == 0) r = ~r;
      if ($urandom % 4 == 0) w = ~w;
      ma = ($urandom % 4 == 0);
      md = ($urandom % 4 == 0);
      if (ma) b = ($urandom & 32'hFFFF_FE00) | $urandom_range(0, 15);
      else    b = $urandom;
      step(($urandom % 97 == 0), r, w, ma, md, ($urandom % 2 == 1), b);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
